// File: rtl/branch_predict_ctrl.sv
// Decode-stage branch/jump resolution with a PC-indexed saturating-counter
// predictor consulted in fetch, plus saturating branch/mispredict statistics.
//
// Handshake note: there is no valid/ready pair here. stalld acts as an
// inverted "decode valid": when stalld=1 nothing in decode is resolved,
// the predictor table and statistics are not updated, and the registered
// fetch prediction (predtakend) is held.
module branch_predict_ctrl #(
  parameter int WIDTH = 32,
  parameter int IDX_W = 6,
  parameter int CTR_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stalld,
  input  logic [WIDTH-1:0] pcf,
  input  logic [WIDTH-1:0] instrf,
  input  logic [WIDTH-1:0] pcd,
  input  logic [WIDTH-1:0] instrd,
  input  logic             equald,
  input  logic             clrstats,
  output logic             predtakenf,
  output logic [1:0]       pcsrcd,
  output logic             flushd,
  output logic [WIDTH-1:0] branchcnt,
  output logic [WIDTH-1:0] misscnt
);

  localparam int DEPTH = 1 << IDX_W;
  // Weakly-not-taken: the largest value whose MSB is still 0.
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'((1 << (CTR_W - 1)) - 1);
  localparam logic [CTR_W-1:0] CTR_MAX  = '1;
  localparam logic [CTR_W-1:0] CTR_ONE  = CTR_W'(1);
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011;

  localparam logic [1:0] SRC_PC4    = 2'b00;
  localparam logic [1:0] SRC_BRANCH = 2'b01;
  localparam logic [1:0] SRC_JUMP   = 2'b10;
  localparam logic [1:0] SRC_RECOV  = 2'b11;

  logic [CTR_W-1:0] pred_table [DEPTH];
  logic             predtakend;

  logic [5:0]       opf, opd;
  logic [IDX_W-1:0] idxf, idxd;
  logic [CTR_W-1:0] ctrf, ctrd;
  logic             brf, beqd, bned, brd, jumpd, takend, resolve;

  // Only the opcode and index fields are consumed; the rest is folded here.
  logic unused_bits;
  assign unused_bits = ^{pcf, pcd, instrf, instrd};

  assign opf  = instrf[WIDTH-1 -: 6];
  assign opd  = instrd[WIDTH-1 -: 6];
  assign idxf = pcf[IDX_W+1:2];
  assign idxd = pcd[IDX_W+1:2];
  assign ctrf = pred_table[idxf];
  assign ctrd = pred_table[idxd];

  assign brf     = (opf == OP_BEQ) || (opf == OP_BNE);
  assign beqd    = (opd == OP_BEQ);
  assign bned    = (opd == OP_BNE);
  assign brd     = beqd || bned;
  assign jumpd   = (opd == OP_J) || (opd == OP_JAL);
  assign takend  = (beqd && equald) || (bned && !equald);
  // A branch in decode that actually resolves this cycle.
  assign resolve = brd && !stalld;

  // Fetch prediction reads the table as it stands (no bypass from decode).
  assign predtakenf = reset && brf && ctrf[CTR_W-1];

  // Decode resolution: pick the fetch PC source and flush on a redirect.
  always_comb begin
    pcsrcd = SRC_PC4;
    flushd = 1'b0;
    if (!stalld) begin
      if (jumpd) begin
        pcsrcd = SRC_JUMP;
        flushd = 1'b1;
      end else if (brd && takend && !predtakend) begin
        pcsrcd = SRC_BRANCH;
        flushd = 1'b1;
      end else if (brd && !takend && predtakend) begin
        pcsrcd = SRC_RECOV;
        flushd = 1'b1;
      end
    end
  end

  // Carry the fetch prediction into decode; a flushed fetch carries none.
  always_ff @(posedge clk) begin
    if (!reset) begin
      predtakend <= 1'b0;
    end else if (!stalld) begin
      predtakend <= flushd ? 1'b0 : predtakenf;
    end
  end

  // Train the counter of the resolving branch, saturating at both ends.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        pred_table[i] <= CTR_INIT;
      end
    end else if (resolve) begin
      if (takend) begin
        if (ctrd != CTR_MAX) pred_table[idxd] <= ctrd + CTR_ONE;
      end else begin
        if (ctrd != '0) pred_table[idxd] <= ctrd - CTR_ONE;
      end
    end
  end

  // Saturating statistics; clrstats wins over a simultaneous increment.
  always_ff @(posedge clk) begin
    if (!reset || clrstats) begin
      branchcnt <= '0;
      misscnt   <= '0;
    end else if (resolve) begin
      if (branchcnt != '1) branchcnt <= branchcnt + CNT_ONE;
      if ((takend != predtakend) && (misscnt != '1)) misscnt <= misscnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Bench for branch_predict_ctrl: a default 32-bit instance driven from a
// vector table, and an 8-bit instance used to reach counter saturation.
module tb_branch_predict_ctrl;

  localparam logic [31:0] BEQ  = 32'h1000_0000;
  localparam logic [31:0] BNE  = 32'h1400_0000;
  localparam logic [31:0] JMP  = 32'h0800_0000;
  localparam logic [31:0] JAL  = 32'h0C00_0000;
  localparam logic [31:0] BLEZ = 32'h1800_0000;
  localparam logic [31:0] NOP  = 32'h0000_0000;
  localparam logic [7:0]  BEQ8 = 8'h10;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- 32-bit instance ----------------
  logic        reset, stalld, equald, clrstats;
  logic [31:0] pcf, instrf, pcd, instrd;
  logic        predtakenf, flushd;
  logic [1:0]  pcsrcd;
  logic [31:0] branchcnt, misscnt;

  branch_predict_ctrl dut (
    .clk(clk), .reset(reset), .stalld(stalld), .pcf(pcf), .instrf(instrf),
    .pcd(pcd), .instrd(instrd), .equald(equald), .clrstats(clrstats),
    .predtakenf(predtakenf), .pcsrcd(pcsrcd), .flushd(flushd),
    .branchcnt(branchcnt), .misscnt(misscnt)
  );

  // ---------------- 8-bit instance ----------------
  logic       s_reset, s_stalld, s_equald, s_clrstats;
  logic [7:0] s_pcf, s_instrf, s_pcd, s_instrd;
  logic       s_predtakenf, s_flushd;
  logic [1:0] s_pcsrcd;
  logic [7:0] s_branchcnt, s_misscnt;

  branch_predict_ctrl #(.WIDTH(8), .IDX_W(4), .CTR_W(2)) dut8 (
    .clk(clk), .reset(s_reset), .stalld(s_stalld), .pcf(s_pcf), .instrf(s_instrf),
    .pcd(s_pcd), .instrd(s_instrd), .equald(s_equald), .clrstats(s_clrstats),
    .predtakenf(s_predtakenf), .pcsrcd(s_pcsrcd), .flushd(s_flushd),
    .branchcnt(s_branchcnt), .misscnt(s_misscnt)
  );

  // ---------------- vectors / scoreboard ----------------
  typedef struct packed {
    logic        rst;
    logic        stall;
    logic        clr;
    logic [31:0] pf;
    logic [31:0] inf;
    logic [31:0] pd;
    logic [31:0] ind;
    logic        eq;
    logic        ptf;
    logic [1:0]  src;
    logic        fl;
    logic [31:0] bc;
    logic [31:0] mc;
  } vec_t;

  vec_t        vecs[$];
  logic [67:0] exp_q[$];
  logic [15:0] exp8_q[$];
  int          checks = 0;
  int          failures = 0;

  function automatic void add(input logic rst, input logic stall, input logic clr,
                              input logic [31:0] pf, input logic [31:0] inf,
                              input logic [31:0] pd, input logic [31:0] ind,
                              input logic eq, input logic ptf, input logic [1:0] src,
                              input logic fl, input logic [31:0] bc, input logic [31:0] mc);
    vec_t v;
    v.rst = rst; v.stall = stall; v.clr = clr;
    v.pf = pf; v.inf = inf; v.pd = pd; v.ind = ind; v.eq = eq;
    v.ptf = ptf; v.src = src; v.fl = fl; v.bc = bc; v.mc = mc;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d actual=%0h required=%0h", name, idx, act, exp);
    end
  endtask

  // Drive one vector after a clock edge, sample combinational outputs mid-cycle,
  // then counters just after the next edge.
  task automatic apply(input vec_t v, input int idx);
    logic        a_ptf, a_fl;
    logic [1:0]  a_src;
    logic [67:0] e;
    reset = v.rst; stalld = v.stall; clrstats = v.clr;
    pcf = v.pf; instrf = v.inf; pcd = v.pd; instrd = v.ind; equald = v.eq;
    exp_q.push_back({v.ptf, v.src, v.fl, v.bc, v.mc});
    #3;
    a_ptf = predtakenf; a_src = pcsrcd; a_fl = flushd;
    @(posedge clk); #1;
    e = exp_q.pop_front();
    chk("predtakenf", idx, {31'd0, a_ptf}, {31'd0, e[67]});
    chk("pcsrcd",     idx, {30'd0, a_src}, {30'd0, e[66:65]});
    chk("flushd",     idx, {31'd0, a_fl},  {31'd0, e[64]});
    chk("branchcnt",  idx, branchcnt, e[63:32]);
    chk("misscnt",    idx, misscnt,   e[31:0]);
  endtask

  // One cycle on the 8-bit instance: branch in decode, counters checked after the edge.
  task automatic apply8(input logic clr, input logic [7:0] ebc, input logic [7:0] emc,
                        input int idx);
    logic [15:0] e;
    s_clrstats = clr; s_instrd = BEQ8; s_pcd = 8'h00; s_equald = 1'b1;
    exp8_q.push_back({ebc, emc});
    @(posedge clk); #1;
    e = exp8_q.pop_front();
    chk("sat_branchcnt", idx, {24'd0, s_branchcnt}, {24'd0, e[15:8]});
    chk("sat_misscnt",   idx, {24'd0, s_misscnt},   {24'd0, e[7:0]});
  endtask

  initial begin
    reset = 1'b0; stalld = 1'b0; clrstats = 1'b0; equald = 1'b0;
    pcf = NOP; instrf = NOP; pcd = NOP; instrd = NOP;
    s_reset = 1'b0; s_stalld = 1'b0; s_clrstats = 1'b0; s_equald = 1'b0;
    s_pcf = 8'h00; s_instrf = 8'h00; s_pcd = 8'h00; s_instrd = 8'h00;

    //   rst stl clr pcf    instrf pcd    instrd eq  ptf src    fl  bc  mc
    add(0, 0, 0, 32'h0,  NOP,  32'h0,  NOP,  0, 0, 2'b00, 0, 0, 0);
    add(0, 0, 0, 32'h40, BEQ,  32'h0,  NOP,  0, 0, 2'b00, 0, 0, 0);
    add(1, 0, 0, 32'h40, BEQ,  32'h0,  NOP,  0, 0, 2'b00, 0, 0, 0);  // 01: not taken
    add(1, 0, 0, 32'h0,  NOP,  32'h40, BEQ,  1, 0, 2'b01, 1, 1, 1);  // miss, 01->10
    add(1, 0, 0, 32'h40, BEQ,  32'h0,  NOP,  0, 1, 2'b00, 0, 1, 1);
    add(1, 0, 0, 32'h0,  NOP,  32'h40, BEQ,  1, 0, 2'b00, 0, 2, 1);  // hit, 10->11
    add(1, 0, 0, 32'h40, BEQ,  32'h0,  NOP,  0, 1, 2'b00, 0, 2, 1);
    add(1, 0, 0, 32'h0,  NOP,  32'h40, BEQ,  1, 0, 2'b00, 0, 3, 1);  // hit, stays 11
    add(1, 0, 0, 32'h40, BEQ,  32'h0,  NOP,  0, 1, 2'b00, 0, 3, 1);
    add(1, 0, 0, 32'h0,  NOP,  32'h40, BEQ,  0, 0, 2'b11, 1, 4, 2);  // recover, 11->10
    add(1, 0, 0, 32'h40, BNE,  32'h0,  NOP,  0, 1, 2'b00, 0, 4, 2);
    add(1, 0, 0, 32'h0,  NOP,  32'h40, BNE,  1, 0, 2'b11, 1, 5, 3);  // bne not taken, 10->01
    add(1, 0, 0, 32'h40, BNE,  32'h0,  NOP,  0, 0, 2'b00, 0, 5, 3);
    add(1, 0, 0, 32'h0,  NOP,  32'h40, BEQ,  1, 0, 2'b01, 1, 6, 4);  // 01->10
    add(1, 0, 0, 32'h40, BEQ,  32'h0,  JMP,  1, 1, 2'b10, 1, 6, 4);  // j flushes prediction
    add(1, 0, 0, 32'h40, BEQ,  32'h40, BEQ,  1, 1, 2'b01, 1, 7, 5);  // predtakend was cleared
    add(1, 0, 0, 32'h40, BEQ,  32'h0,  JAL,  0, 1, 2'b10, 1, 7, 5);
    add(1, 0, 0, 32'h0,  NOP,  32'h40, BNE,  0, 0, 2'b01, 1, 8, 6);  // bne taken
    add(1, 0, 0, 32'h40, BEQ,  32'h0,  NOP,  0, 1, 2'b00, 0, 8, 6);  // predtakend <- 1
    add(1, 1, 0, 32'h0,  NOP,  32'h40, BEQ,  1, 0, 2'b00, 0, 8, 6);  // stalled x3
    add(1, 1, 0, 32'h0,  NOP,  32'h40, BEQ,  1, 0, 2'b00, 0, 8, 6);
    add(1, 1, 0, 32'h0,  NOP,  32'h40, BEQ,  1, 0, 2'b00, 0, 8, 6);
    add(1, 0, 0, 32'h0,  NOP,  32'h40, BEQ,  1, 0, 2'b00, 0, 9, 6);  // held prediction used
    add(1, 0, 0, 32'h40, BEQ,  32'h40, BEQ,  0, 1, 2'b00, 0, 10, 6); // 11->10
    add(1, 0, 0, 32'h40, BEQ,  32'h40, BEQ,  0, 1, 2'b11, 1, 11, 7); // fetch sees pre-update 10
    add(1, 0, 1, 32'h0,  NOP,  32'h40, BEQ,  1, 0, 2'b01, 1, 0, 0);  // clr beats increment
    add(1, 0, 0, 32'h40, BEQ,  32'h0,  NOP,  0, 1, 2'b00, 0, 0, 0);  // table kept (10)
    add(1, 0, 0, 32'h44, BEQ,  32'h0,  NOP,  0, 0, 2'b00, 0, 0, 0);  // other index still 01
    add(1, 1, 0, 32'h0,  NOP,  32'h0,  JMP,  0, 0, 2'b00, 0, 0, 0);  // stalled jump
    add(1, 0, 0, 32'h0,  NOP,  32'h0,  BLEZ, 1, 0, 2'b00, 0, 0, 0);  // non-control
    add(1, 0, 0, 32'h40, BEQ,  32'h40, BNE,  0, 1, 2'b01, 1, 1, 1);  // 10->11
    add(1, 0, 0, 32'h40, BEQ,  32'h0,  NOP,  0, 1, 2'b00, 0, 1, 1);  // predtakend <- 1
    add(0, 1, 0, 32'h40, BEQ,  32'h0,  NOP,  0, 0, 2'b00, 0, 0, 0);  // mid-stream reset
    add(1, 0, 0, 32'h40, BEQ,  32'h40, BEQ,  1, 0, 2'b01, 1, 1, 1);  // table 01, predtakend 0
    add(1, 0, 0, 32'h40, BEQ,  32'h0,  NOP,  0, 1, 2'b00, 0, 1, 1);

    @(posedge clk); #1;
    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Saturation on the 8-bit build: every branch is taken with no prediction,
    // so both counters climb together and must pin at 0xFF.
    s_reset = 1'b1;
    chk("sat_reset_branchcnt", 0, {24'd0, s_branchcnt}, 32'd0);
    for (int n = 1; n <= 260; n++) begin
      apply8(1'b0, (n > 255) ? 8'hFF : 8'(n), (n > 255) ? 8'hFF : 8'(n), n);
    end
    apply8(1'b1, 8'h00, 8'h00, 261);
    apply8(1'b0, 8'h01, 8'h01, 262);

    if (exp_q.size() != 0 || exp8_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size() + exp8_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
